mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous assertion, active-low (0 = in reset).
REQ-003 SHALL have ports: inst_req in 1 fetch request; inst_addr in 32; inst_rdata out 32 fetched word; inst_stall out 1.
REQ-004 SHALL have ports: data_req in 1; data_wr in 1 (1 = store); data_wstrb in 4 byte enables; data_addr in 32; data_wdata in 32; data_rdata out 32; data_stall out 1.
REQ-005 SHALL have ports: cpu_stall in 1, pipeline-wide stall (longest stall) from the CPU.
REQ-006 SHALL have ports: mem_req out 1; mem_wr out 1; mem_wstrb out 4; mem_addr out 32; mem_wdata out 32; mem_addr_ok in 1; mem_data_ok in 1; mem_rdata in 32. This is a single-outstanding sram-like port.

Function
REQ-007 SHALL share one memory port between the fetch and data requesters, with at most one transaction outstanding.
REQ-008 SHALL implement FSM states IDLE, ADDR, DATA, plus a 1-bit owner register (0 = inst, 1 = data).
REQ-009 In IDLE, grant SHALL go to data when data_req=1 and data_done=0; otherwise to inst when inst_req=1 and inst_done=0; otherwise stay IDLE.
REQ-010 On a grant, SHALL latch the owner's addr, wr, wstrb and wdata (inst: wr=0, wstrb=0000, wdata=0), then enter ADDR next cycle. Requester input changes after the grant SHALL be ignored.
REQ-011 In ADDR, mem_req=1 with the latched fields. On mem_addr_ok=1, SHALL go to DATA; mem_req SHALL be 0 in DATA and IDLE.
REQ-012 In DATA, on mem_data_ok=1: a read SHALL capture mem_rdata into the owner's rdata register; SHALL set the owner's done flag; SHALL return to IDLE.
REQ-013 A write SHALL leave data_rdata unchanged.
REQ-014 inst_stall = inst_req & ~inst_done; data_stall = data_req & ~data_done. Both combinational, so stall falls in the cycle after mem_data_ok.
REQ-015 Minimum latency, grant to done: 3 cycles (IDLE grant, ADDR with addr_ok, DATA with data_ok). Each extra wait cycle adds 1.
REQ-016 inst_rdata and data_rdata SHALL hold their value until the next read completion for the same owner.
REQ-017 A done flag SHALL clear on any cycle with cpu_stall=0. Set (mem_data_ok) SHALL take precedence over clear in the same cycle.
REQ-018 While done=1 and cpu_stall=1, the same requester SHALL NOT be re-granted, so no duplicate access occurs.
REQ-019 When data_req and inst_req are both pending, data SHALL be served first; inst SHALL be granted in the IDLE cycle right after the data transaction completes.
REQ-020 mem_data_ok in IDLE or ADDR SHALL be ignored. mem_addr_ok outside ADDR SHALL be ignored.
REQ-021 Deassertion of a requester's req after grant SHALL NOT abort the transaction. The transaction completes and sets done.

Reset
REQ-022 While rst=0: state=IDLE; owner=0; inst_done=data_done=0; inst_rdata=data_rdata=0; latched fields=0; mem_req=0. All outputs are 0.
REQ-023 Reset mid-transaction SHALL abandon it immediately (downstream is reset in the same domain); no done flag is set.

Verification
REQ-024 Read, instant handshake: inst_req=1, addr=0xBFC00000, addr_ok on the first ADDR cycle, data_ok next cycle with rdata=0x3C1D0001 -> inst_rdata=0x3C1D0001, inst_stall falls 3 cycles after req rise.
REQ-025 Contention: inst_req and data_req (load, addr=0x80001000) rise in the same cycle -> the data address appears on mem_addr first; inst is granted in the IDLE cycle after the data mem_data_ok.
REQ-026 Store: data_wr=1, wstrb=0011, wdata=0xDEADBEEF, 2 addr_ok wait cycles -> mem_wr=1, mem_wstrb=0011, mem_wdata=0xDEADBEEF held through ADDR; data_rdata unchanged; latency 5.
REQ-027 Held stall: after a fetch completes, hold cpu_stall=1 for 4 cycles -> no new mem_req for inst and inst_rdata is stable; drop cpu_stall -> inst_done clears and a new fetch is granted.
REQ-028 Reset mid-DATA: rst=0 for 1 cycle during DATA -> state IDLE, mem_req=0, both done=0, rdata=0; a stale mem_data_ok pulse afterwards is ignored.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch/data requester signals and the shared sram-like memory port
// that mem_port_arbiter multiplexes between them.
interface mem_port_arbiter_if;
    // Fetch requester
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_stall;

    // Load/store requester
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_stall;

    // Pipeline-wide stall from the CPU
    logic        cpu_stall;

    // Single-outstanding memory port
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    // CPU and memory side: drives requests and memory responses
    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output cpu_stall,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  inst_rdata, inst_stall, data_rdata, data_stall,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );

    // Arbiter side
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  cpu_stall,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output inst_rdata, inst_stall, data_rdata, data_stall,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding sram-like memory port between instruction fetch
// and data access; data wins contention, completions are held as per-owner done flags.
module mem_port_arbiter (
    input  logic                      clk,
    input  logic                      rst,
    mem_port_arbiter_if.slave         bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int N_OWNER    = 2;
    localparam bit OWNER_INST = 1'b0;
    localparam bit OWNER_DATA = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        req_wr_q, req_wr_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;

    logic [N_OWNER-1:0] done_all;
    logic [31:0]        rdata_all [N_OWNER];

    logic inst_pend;
    logic data_pend;
    logic complete;

    assign inst_pend = bus.inst_req & ~done_all[OWNER_INST];
    assign data_pend = bus.data_req & ~done_all[OWNER_DATA];
    // mem_data_ok only means something while a transaction waits for data
    assign complete  = (state_q == ST_DATA) & bus.mem_data_ok;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_wr_d    = req_wr_q;
        req_wstrb_d = req_wstrb_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (data_pend) begin
                    state_d     = ST_ADDR;
                    owner_d     = OWNER_DATA;
                    req_wr_d    = bus.data_wr;
                    req_wstrb_d = bus.data_wstrb;
                    req_addr_d  = bus.data_addr;
                    req_wdata_d = bus.data_wdata;
                end else if (inst_pend) begin
                    state_d     = ST_ADDR;
                    owner_d     = OWNER_INST;
                    req_wr_d    = 1'b0;
                    req_wstrb_d = 4'b0000;
                    req_addr_d  = bus.inst_addr;
                    req_wdata_d = 32'h0;
                end
            end
            ST_ADDR: begin
                if (bus.mem_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.mem_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_INST;
            req_wr_q    <= 1'b0;
            req_wstrb_q <= 4'b0000;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_wr_q    <= req_wr_d;
            req_wstrb_q <= req_wstrb_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    // Per-owner completion flag and read-data holding register
    genvar gi;
    generate
        for (gi = 0; gi < N_OWNER; gi++) begin : g_owner
            logic        owner_hit;
            logic        done_q, done_d;
            logic [31:0] rdata_q, rdata_d;

            assign owner_hit = complete & (owner_q == 1'(gi));

            // Completion beats the clear so a finish during cpu_stall=0 is still seen
            always_comb begin
                done_d  = done_q;
                rdata_d = rdata_q;
                if (owner_hit) begin
                    done_d = 1'b1;
                end else if (!bus.cpu_stall) begin
                    done_d = 1'b0;
                end
                if (owner_hit && !req_wr_q) begin
                    rdata_d = bus.mem_rdata;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    done_q  <= 1'b0;
                    rdata_q <= 32'h0;
                end else begin
                    done_q  <= done_d;
                    rdata_q <= rdata_d;
                end
            end

            assign done_all[gi]  = done_q;
            assign rdata_all[gi] = rdata_q;
        end
    endgenerate

    assign bus.inst_rdata = rdata_all[OWNER_INST];
    assign bus.data_rdata = rdata_all[OWNER_DATA];
    assign bus.inst_stall = inst_pend;
    assign bus.data_stall = data_pend;

    assign bus.mem_req   = (state_q == ST_ADDR);
    assign bus.mem_wr    = req_wr_q;
    assign bus.mem_wstrb = req_wstrb_q;
    assign bus.mem_addr  = req_addr_q;
    assign bus.mem_wdata = req_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, store with waits,
// held cpu_stall, req drop after grant, and reset in the middle of DATA.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // Advance one clock; all sampling and driving happens 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst             = 1'b0;
        bus.inst_req    = 1'b0;
        bus.inst_addr   = 32'h0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_wstrb  = 4'b0000;
        bus.data_addr   = 32'h0;
        bus.data_wdata  = 32'h0;
        bus.cpu_stall   = 1'b0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;

        // Reset state
        step();
        step();
        check_val("rst_mem_req",    32'(bus.mem_req), 32'd0);
        check_val("rst_mem_addr",   bus.mem_addr, 32'h0);
        check_val("rst_inst_rdata", bus.inst_rdata, 32'h0);
        check_val("rst_data_rdata", bus.data_rdata, 32'h0);
        check_val("rst_stalls",     {30'd0, bus.inst_stall, bus.data_stall}, 32'd0);
        rst = 1'b1;
        step();

        // Fetch with instant handshake
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC00000;
        #1;
        check_val("f1_stall_rise", 32'(bus.inst_stall), 32'd1);
        step();
        check_val("f1_mem_req",  32'(bus.mem_req), 32'd1);
        check_val("f1_mem_addr", bus.mem_addr, 32'hBFC00000);
        check_val("f1_mem_wr",   32'(bus.mem_wr), 32'd0);
        bus.mem_addr_ok = 1'b1;
        step();
        check_val("f1_data_noreq", 32'(bus.mem_req), 32'd0);
        check_val("f1_stall_data", 32'(bus.inst_stall), 32'd1);
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h3C1D0001;
        step();
        check_val("f1_stall_fall", 32'(bus.inst_stall), 32'd0);
        check_val("f1_rdata",      bus.inst_rdata, 32'h3C1D0001);
        bus.mem_data_ok = 1'b0;
        bus.inst_req    = 1'b0;
        step();

        // Contention: data load beats the fetch
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC00004;
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b0;
        bus.data_addr = 32'h80001000;
        step();
        check_val("c_first_addr",  bus.mem_addr, 32'h80001000);
        check_val("c_inst_waits",  32'(bus.inst_stall), 32'd1);
        bus.mem_addr_ok = 1'b1;
        step();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h11112222;
        step();
        check_val("c_data_rdata",  bus.data_rdata, 32'h11112222);
        check_val("c_data_stall",  32'(bus.data_stall), 32'd0);
        check_val("c_idle_noreq",  32'(bus.mem_req), 32'd0);
        bus.mem_data_ok = 1'b0;
        bus.data_req    = 1'b0;
        step();
        check_val("c_inst_granted", 32'(bus.mem_req), 32'd1);
        check_val("c_inst_addr",    bus.mem_addr, 32'hBFC00004);
        bus.mem_addr_ok = 1'b1;
        step();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h24420001;
        step();
        check_val("c_inst_rdata", bus.inst_rdata, 32'h24420001);
        check_val("c_data_kept",  bus.data_rdata, 32'h11112222);
        bus.mem_data_ok = 1'b0;
        bus.inst_req    = 1'b0;
        step();

        // Store with two addr_ok wait cycles; a stray data_ok in ADDR is ignored
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'b1;
        bus.data_wstrb = 4'b0011;
        bus.data_addr  = 32'h80002000;
        bus.data_wdata = 32'hDEADBEEF;
        step();
        check_val("s_mem_req",   32'(bus.mem_req), 32'd1);
        check_val("s_mem_wr",    32'(bus.mem_wr), 32'd1);
        check_val("s_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
        check_val("s_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        bus.data_wdata  = 32'h0;
        bus.data_wstrb  = 4'b1111;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h77777777;
        step();
        bus.mem_data_ok = 1'b0;
        check_val("s_wait1_req",   32'(bus.mem_req), 32'd1);
        check_val("s_wait1_stall", 32'(bus.data_stall), 32'd1);
        check_val("s_wait1_wdata", bus.mem_wdata, 32'hDEADBEEF);
        step();
        check_val("s_wait2_wstrb", 32'(bus.mem_wstrb), 32'h3);
        bus.mem_addr_ok = 1'b1;
        step();
        check_val("s_data_stall", 32'(bus.data_stall), 32'd1);
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h55555555;
        step();
        check_val("s_lat5_stall", 32'(bus.data_stall), 32'd0);
        check_val("s_rdata_kept", bus.data_rdata, 32'h11112222);
        bus.mem_data_ok = 1'b0;
        bus.data_req    = 1'b0;
        bus.data_wr     = 1'b0;
        bus.data_wstrb  = 4'b0000;
        step();

        // Held cpu_stall after a fetch blocks a duplicate grant
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC00008;
        bus.cpu_stall = 1'b1;
        step();
        bus.mem_addr_ok = 1'b1;
        step();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h8C080000;
        step();
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("h_noreq_%0d", i), 32'(bus.mem_req), 32'd0);
            check_val($sformatf("h_rdata_%0d", i), bus.inst_rdata, 32'h8C080000);
        end
        bus.cpu_stall = 1'b0;
        step();
        check_val("h_done_clear", 32'(bus.inst_stall), 32'd1);
        check_val("h_not_yet",    32'(bus.mem_req), 32'd0);
        step();
        check_val("h_regrant",    32'(bus.mem_req), 32'd1);
        check_val("h_regrant_ad", bus.mem_addr, 32'hBFC00008);
        bus.mem_addr_ok = 1'b1;
        step();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h12345678;
        step();
        check_val("h_rdata_new", bus.inst_rdata, 32'h12345678);
        bus.mem_data_ok = 1'b0;
        bus.inst_req    = 1'b0;
        step();

        // Dropping data_req after grant does not abort the load
        bus.data_req  = 1'b1;
        bus.data_addr = 32'h80003000;
        step();
        bus.data_req  = 1'b0;
        bus.data_addr = 32'h0;
        check_val("d_addr", bus.mem_addr, 32'h80003000);
        bus.mem_addr_ok = 1'b1;
        step();
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'h0BADF00D;
        step();
        check_val("d_rdata", bus.data_rdata, 32'h0BADF00D);
        bus.mem_data_ok = 1'b0;
        step();

        // Reset in the middle of DATA, then a stale data_ok
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0000C;
        step();
        bus.mem_addr_ok = 1'b1;
        step();
        bus.mem_addr_ok = 1'b0;
        bus.inst_req    = 1'b0;
        rst             = 1'b0;
        #1;
        check_val("r_mem_req",    32'(bus.mem_req), 32'd0);
        check_val("r_inst_rdata", bus.inst_rdata, 32'h0);
        check_val("r_data_rdata", bus.data_rdata, 32'h0);
        check_val("r_mem_addr",   bus.mem_addr, 32'h0);
        step();
        rst             = 1'b1;
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = 32'hCAFEBABE;
        step();
        bus.mem_data_ok = 1'b0;
        check_val("r_stale_inst", bus.inst_rdata, 32'h0);
        check_val("r_stale_data", bus.data_rdata, 32'h0);
        check_val("r_stale_req",  32'(bus.mem_req), 32'd0);
        bus.inst_req = 1'b1;
        #1;
        check_val("r_done_clear", 32'(bus.inst_stall), 32'd1);
        bus.inst_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
